// File: rtl/io_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : io_arb_pkg
// Brief  : Shared widths, rw encoding and FSM states for io_bus_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package io_arb_pkg;

  localparam int IO_DATA_W = 16;
  localparam int IO_ADDR_W = 16;
  localparam int IO_BE_W   = 2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/io_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : io_bus_arbiter_if
// Brief  : Requester-side and bridge-side signals of the I/O bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface io_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import io_arb_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_rw;
  logic [IO_ADDR_W*NUM_REQ-1:0] req_address;
  logic [IO_BE_W*NUM_REQ-1:0]   req_byte_enable;
  logic [IO_DATA_W*NUM_REQ-1:0] req_write_data;
  logic [NUM_REQ-1:0]           req_done;
  logic [NUM_REQ-1:0]           req_error;
  logic [IO_DATA_W-1:0]         rd_data;

  logic [IO_ADDR_W-1:0]         io_address;
  logic                         io_bus_enable;
  logic [IO_BE_W-1:0]           io_byte_enable;
  logic                         io_rw;
  logic [IO_DATA_W-1:0]         io_write_data;
  logic                         io_acknowledge;
  logic [IO_DATA_W-1:0]         io_read_data;

  // The arbiter is the bus master towards the bridge.
  modport master (
    input  req_valid, req_rw, req_address, req_byte_enable, req_write_data,
    output req_done, req_error, rd_data,
    output io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
    input  io_acknowledge, io_read_data
  );

  modport slave (
    output req_valid, req_rw, req_address, req_byte_enable, req_write_data,
    input  req_done, req_error, rd_data,
    input  io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
    output io_acknowledge, io_read_data
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker, search starts after last_grant.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  wire logic [NUM_REQ-1:0] req_valid,
  input  wire logic [IDX_W-1:0]   last_grant,
  output logic      [NUM_REQ-1:0] grant,
  output logic      [IDX_W-1:0]   index,
  output logic                    found
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    grant  = '0;
    index  = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req_valid[w_cand]) begin
        found         = 1'b1;
        grant[w_cand] = 1'b1;
        index         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : io_bus_arbiter
// Brief  : Round-robin arbiter serialising requesters onto one I/O bridge.
// Rev    : 1.0  initial release
// ============================================================================
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input wire logic         clk_clk,
  input wire logic         reset_reset,
  io_bus_arbiter_if.master bus
);

  localparam int                IDX_W      = $clog2(NUM_REQ);
  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);

  arb_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_last_grant;
  logic [IDX_W-1:0]     r_winner;
  logic [NUM_REQ-1:0]   r_winner_oh;
  logic                 r_io_bus_enable;
  logic [IO_ADDR_W-1:0] r_io_address;
  logic [IO_BE_W-1:0]   r_io_byte_enable;
  logic                 r_io_rw;
  logic [IO_DATA_W-1:0] r_io_write_data;
  logic [NUM_REQ-1:0]   r_req_done;
  logic [NUM_REQ-1:0]   r_req_error;
  logic [IO_DATA_W-1:0] r_rd_data;

  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_found;
  logic [CNT_W-1:0]     w_cnt_next;

  logic [IO_ADDR_W-1:0] w_addr [NUM_REQ];
  logic [IO_BE_W-1:0]   w_be   [NUM_REQ];
  logic [IO_DATA_W-1:0] w_wdat [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_addr[i] = bus.req_address[IO_ADDR_W*i +: IO_ADDR_W];
    assign w_be[i]   = bus.req_byte_enable[IO_BE_W*i +: IO_BE_W];
    assign w_wdat[i] = bus.req_write_data[IO_DATA_W*i +: IO_DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_valid  (bus.req_valid),
    .last_grant (r_last_grant),
    .grant      (w_pick_oh),
    .index      (w_pick_idx),
    .found      (w_pick_found)
  );

  assign w_cnt_next = r_cnt + CNT_W'(1);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_last_grant     <= LAST_RESET;
      r_winner         <= '0;
      r_winner_oh      <= '0;
      r_io_bus_enable  <= 1'b0;
      r_io_address     <= '0;
      r_io_byte_enable <= '0;
      r_io_rw          <= RW_WRITE;
      r_io_write_data  <= '0;
      r_req_done       <= '0;
      r_req_error      <= '0;
      r_rd_data        <= '0;
    end else begin
      r_req_done  <= '0;
      r_req_error <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_winner         <= w_pick_idx;
            r_winner_oh      <= w_pick_oh;
            r_io_rw          <= bus.req_rw[w_pick_idx];
            r_io_address     <= w_addr[w_pick_idx];
            r_io_byte_enable <= w_be[w_pick_idx];
            r_io_write_data  <= w_wdat[w_pick_idx];
            r_io_bus_enable  <= 1'b1;
            r_cnt            <= '0;
            r_state          <= ISSUE;
          end
        end
        ISSUE: begin
          // Acknowledge is tested first so it wins over a same-cycle timeout.
          if (bus.io_acknowledge) begin
            if (r_io_rw == RW_READ) begin
              r_rd_data <= bus.io_read_data;
            end
            r_req_done      <= r_winner_oh;
            r_io_bus_enable <= 1'b0;
            r_state         <= DONE;
          end else if (w_cnt_next == CNT_LIMIT) begin
            r_req_error     <= r_winner_oh;
            r_rd_data       <= '0;
            r_io_bus_enable <= 1'b0;
            r_state         <= DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        DONE: begin
          r_last_grant <= r_winner;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_done       = r_req_done;
  assign bus.req_error      = r_req_error;
  assign bus.rd_data        = r_rd_data;
  assign bus.io_address     = r_io_address;
  assign bus.io_bus_enable  = r_io_bus_enable;
  assign bus.io_byte_enable = r_io_byte_enable;
  assign bus.io_rw          = r_io_rw;
  assign bus.io_write_data  = r_io_write_data;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_io_bus_arbiter
// Brief  : Randomised scoreboard bench for io_bus_arbiter with a TLM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_io_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  io_bus_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  typedef struct {
    int          w;
    logic        rw;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } issue_t;

  typedef struct {
    int          w;
    bit          err;
    logic [15:0] rd;
    int          dur;
  } comp_t;

  issue_t issue_q[$];
  comp_t  comp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: transaction-level view of the arbiter.
  int          mdl_lg   = N - 1;
  logic [15:0] mdl_rd   = 16'h0000;
  bit          resp_busy = 1'b0;
  int          resp_cnt  = 0;
  int          ack_at    = 0;
  logic [15:0] resp_rdat = 16'h0000;
  bit          inflight [N];
  int          mode      = 0;
  logic [N-1:0] allow    = '1;
  int          req_pct   = 30;
  bit          mon_en    = 1'b0;

  logic        rq_rw   [N];
  logic [15:0] rq_addr [N];
  logic [1:0]  rq_be   [N];
  logic [15:0] rq_wd   [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_true(input string name, input bit ok, input int val);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: observed %0d violates rule at %0t", name, val, $time);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int lg);
    for (int s = 1; s <= N; s++) begin
      if (v[(lg + s) % N]) return (lg + s) % N;
    end
    return -1;
  endfunction

  function automatic int pick_delay();
    int r;
    case (mode)
      1: return 0;
      2: return TO + 3;
      3: return TO - 1;
      default: begin
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return TO - 1;
        if (r == 8) return TO - 2;
        return TO + 3;
      end
    endcase
  endfunction

  task automatic new_request(input int i);
    rq_rw[i]   = 1'($urandom_range(0, 1));
    rq_addr[i] = 16'($urandom);
    rq_be[i]   = 2'($urandom_range(1, 3));
    rq_wd[i]   = 16'($urandom);
    bus.req_rw[i]                 = rq_rw[i];
    bus.req_address[16*i +: 16]   = rq_addr[i];
    bus.req_byte_enable[2*i +: 2] = rq_be[i];
    bus.req_write_data[16*i +: 16] = rq_wd[i];
    bus.req_valid[i]              = 1'b1;
  endtask

  // Called at each falling edge: drives requesters and the bridge responder,
  // and pushes the predicted issue/completion of each new transaction.
  task automatic step();
    int           w;
    issue_t       it;
    comp_t        ct;
    logic [N-1:0] snap;
    snap = bus.req_valid;
    bus.io_acknowledge = 1'b0;
    bus.io_read_data   = 16'($urandom);
    if (resp_busy && (bus.req_done != '0 || bus.req_error != '0)) resp_busy = 1'b0;
    if (!resp_busy && bus.io_bus_enable) begin
      w = rr_next(snap, mdl_lg);
      chk_true("grant_has_request", w >= 0, w);
      if (w >= 0) begin
        ack_at    = pick_delay();
        resp_rdat = 16'($urandom);
        resp_busy = 1'b1;
        resp_cnt  = 0;
        it.w = w; it.rw = rq_rw[w]; it.addr = rq_addr[w]; it.be = rq_be[w]; it.wd = rq_wd[w];
        issue_q.push_back(it);
        ct.w   = w;
        ct.err = (ack_at >= TO);
        if (ct.err)             ct.rd = 16'h0000;
        else if (rq_rw[w])      ct.rd = resp_rdat;
        else                    ct.rd = mdl_rd;
        ct.dur = ct.err ? TO : ack_at + 1;
        comp_q.push_back(ct);
        mdl_rd      = ct.rd;
        mdl_lg      = w;
        inflight[w] = 1'b1;
        if ($urandom_range(0, 7) == 0) bus.req_valid[w] = 1'b0;
      end
    end
    if (resp_busy && bus.io_bus_enable) begin
      if (resp_cnt == ack_at) begin
        bus.io_acknowledge = 1'b1;
        bus.io_read_data   = resp_rdat;
      end
      resp_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_done[i] || bus.req_error[i]) begin
        bus.req_valid[i] = 1'b0;
        inflight[i]      = 1'b0;
      end else if (!bus.req_valid[i] && !inflight[i] && allow[i] &&
                   $urandom_range(0, 99) < req_pct) begin
        new_request(i);
      end
    end
  endtask

  // Monitor: compares DUT activity against the queued expectations.
  int     en_run  = 0;
  int     low_run = 0;
  bit     have_cur = 1'b0;
  bit     seen_txn = 1'b0;
  issue_t cur;
  comp_t  cc;

  always @(negedge clk) begin
    #1;
    if (rst || !mon_en) begin
      en_run = 0; low_run = 0; have_cur = 1'b0; seen_txn = 1'b0;
    end else if (bus.io_bus_enable) begin
      if (en_run == 0) begin
        if (seen_txn) chk_true("idle_gap", low_run >= 2, low_run);
        chk_true("pending_issue", issue_q.size() != 0, issue_q.size());
        have_cur = (issue_q.size() != 0);
        if (have_cur) cur = issue_q.pop_front();
      end
      if (have_cur) begin
        chk("io_rw",          32'(bus.io_rw),          32'(cur.rw));
        chk("io_address",     32'(bus.io_address),     32'(cur.addr));
        chk("io_byte_enable", 32'(bus.io_byte_enable), 32'(cur.be));
        chk("io_write_data",  32'(bus.io_write_data),  32'(cur.wd));
      end
      en_run++;
      low_run = 0;
    end else begin
      if (bus.req_done != '0 || bus.req_error != '0) begin
        chk_true("pending_completion", comp_q.size() != 0, comp_q.size());
        if (comp_q.size() != 0) begin
          cc = comp_q.pop_front();
          chk("req_done",      32'(bus.req_done),  cc.err ? 32'd0 : (32'd1 << cc.w));
          chk("req_error",     32'(bus.req_error), cc.err ? (32'd1 << cc.w) : 32'd0);
          chk("rd_data",       32'(bus.rd_data),   32'(cc.rd));
          chk("enable_cycles", 32'(en_run),        32'(cc.dur));
        end
        seen_txn = 1'b1;
      end else if (en_run != 0) begin
        chk_true("completion_after_enable", 1'b0, en_run);
      end
      en_run = 0;
      low_run++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_enable"},  32'(bus.io_bus_enable),  32'd0);
    chk({tag, "_address"},     32'(bus.io_address),     32'd0);
    chk({tag, "_byte_enable"}, 32'(bus.io_byte_enable), 32'd0);
    chk({tag, "_rw"},          32'(bus.io_rw),          32'd0);
    chk({tag, "_write_data"},  32'(bus.io_write_data),  32'd0);
    chk({tag, "_req_done"},    32'(bus.req_done),       32'd0);
    chk({tag, "_req_error"},   32'(bus.req_error),      32'd0);
    chk({tag, "_rd_data"},     32'(bus.rd_data),        32'd0);
  endtask

  task automatic drain(input string tag);
    bit idle;
    req_pct = 0;
    idle    = 1'b0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge clk);
      step();
      idle = (bus.req_valid == '0) && !resp_busy && !bus.io_bus_enable &&
             (issue_q.size() == 0) && (comp_q.size() == 0);
    end
    chk_true(tag, idle, issue_q.size() + comp_q.size());
    repeat (3) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    bus.req_valid       = '0;
    bus.req_rw          = '0;
    bus.req_address     = '0;
    bus.req_byte_enable = '0;
    bus.req_write_data  = '0;
    bus.io_acknowledge  = 1'b0;
    bus.io_read_data    = 16'h0000;
    for (int i = 0; i < N; i++) inflight[i] = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    mode = 0; allow = '1;     req_pct = 30;  run(500);
    mode = 1; allow = 3'b011; req_pct = 100; run(80);
    mode = 2; allow = 3'b100; req_pct = 100; run(60);
    mode = 3; allow = '1;     req_pct = 40;  run(60);
    mode = 0; allow = '1;     req_pct = 50;  run(200);
    drain("drain_before_reset");

    // Abort a transaction with reset on its second ISSUE cycle.
    mon_en = 1'b0;
    new_request(1);
    for (int c = 0; c < 10 && !bus.io_bus_enable; c++) @(negedge clk);
    chk("abort_issue_started", 32'(bus.io_bus_enable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    issue_q.delete();
    comp_q.delete();
    mdl_lg    = N - 1;
    mdl_rd    = 16'h0000;
    resp_busy = 1'b0;
    bus.req_valid      = '0;
    bus.io_acknowledge = 1'b0;
    for (int i = 0; i < N; i++) inflight[i] = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    new_request(0);
    new_request(1);
    mode = 1; allow = 3'b011; req_pct = 100; run(40);
    mode = 0; allow = '1;     req_pct = 30;  run(150);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
